pc_unit: RTL and testbench

Parametrised program-counter unit that replaces the bare PC register in the fetch stage. It holds the fetch address, advances it sequentially, and applies exceptions, jumps and taken branches by fixed priority. A redirect that arrives while fetch is stalled is held in a one-entry pending slot instead of being dropped. It drives the instruction-memory address and the link value for the register file.

---
 rtl/pc_unit.sv | 158 +++++++++++++++
 tb/tb_pc_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance plus exception/jump/branch redirects by
// fixed priority, with a one-entry pending slot for redirects that arrive under stall.
// Optional feature macro: PC_ALIGN_CHECK_EN traps misaligned redirect targets to EXC_VECTOR.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h0000_0080
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] PC_plus,
    output logic             pc_valid,
    output logic             redirected,
    output logic             misalign
);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic             r_pend_valid;
    logic             w_pend_valid_nxt;
    logic [WIDTH-1:0] r_pend_target;
    logic [WIDTH-1:0] w_pend_target_nxt;
    logic             r_pc_valid;
    logic             r_redirected;
    logic             w_redirected_nxt;
    logic             r_misalign;
    logic             w_misalign_nxt;
    logic             w_redir_present;
    logic [WIDTH-1:0] w_redir_target;
    logic             w_live_bad;
    logic             w_pend_bad;

    assign w_redir_present = jump | branch_taken;
    assign w_redir_target  = jump ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
    // Low address bits that must be zero; INC = 1 gives an empty mask, disabling the check.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    function automatic logic is_misaligned(input logic [WIDTH-1:0] target);
        return |(target & ALIGN_MASK);
    endfunction

    assign w_live_bad = is_misaligned(w_redir_target);
    assign w_pend_bad = is_misaligned(r_pend_target);
`else
    assign w_live_bad = 1'b0;
    assign w_pend_bad = 1'b0;
`endif

    // State register and all registered outputs; reset discards any pending redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend_valid  <= 1'b0;
            r_pend_target <= {WIDTH{1'b0}};
            r_pc_valid    <= 1'b0;
            r_redirected  <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_pc_valid    <= (w_state_nxt == S_RUN);
            r_redirected  <= w_redirected_nxt;
            r_misalign    <= w_misalign_nxt;
        end
    end

    // Next-state logic: BOOT lasts exactly one cycle, RUN is left only through reset.
    always_comb begin
        w_state_nxt = S_BOOT;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // PC selection by priority: exception, stall capture/hold, live redirect, pending, increment.
    always_comb begin
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_redirected_nxt  = 1'b0;
        w_misalign_nxt    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_pc_nxt         = RESET_VECTOR;
                w_pend_valid_nxt = 1'b0;
            end
            S_RUN: begin
                if (exc) begin
                    w_pc_nxt         = EXC_VECTOR;
                    w_pend_valid_nxt = 1'b0;
                    w_redirected_nxt = 1'b1;
                end else if (stall) begin
                    if (w_redir_present) begin
                        w_pend_target_nxt = w_redir_target;
                        w_pend_valid_nxt  = 1'b1;
                    end else begin
                        w_pend_valid_nxt  = r_pend_valid;
                    end
                end else if (w_redir_present) begin
                    w_pend_valid_nxt = 1'b0;
                    w_redirected_nxt = 1'b1;
                    if (w_live_bad) begin
                        w_pc_nxt       = EXC_VECTOR;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_pc_nxt       = w_redir_target;
                    end
                end else if (r_pend_valid) begin
                    w_pend_valid_nxt = 1'b0;
                    w_redirected_nxt = 1'b1;
                    if (w_pend_bad) begin
                        w_pc_nxt       = EXC_VECTOR;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_pc_nxt       = r_pend_target;
                    end
                end else begin
                    w_pc_nxt = r_pc + INC_W;
                end
            end
            default: begin
                w_pc_nxt         = RESET_VECTOR;
                w_pend_valid_nxt = 1'b0;
            end
        endcase
    end

    assign PC_out     = r_pc;
    assign PC_plus    = r_pc + INC_W;
    assign pc_valid   = r_pc_valid;
    assign redirected = r_redirected;
    assign misalign   = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes the expected post-edge outputs from a
// rule-level model; a monitor pops and compares one entry after every rising edge.
module tb_pc_unit;

    localparam int          WIDTH = 32;
    localparam int          INC   = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] EV    = 32'h0000_0080;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        exc;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] PC_out;
    logic [31:0] PC_plus;
    logic        pc_valid;
    logic        redirected;
    logic        misalign;

    pc_unit #(.WIDTH(WIDTH), .INC(INC), .RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clock(clock), .reset(reset), .stall(stall), .exc(exc),
        .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .PC_out(PC_out), .PC_plus(PC_plus), .pc_valid(pc_valid),
        .redirected(redirected), .misalign(misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] plus;
        logic        valid;
        logic        redir;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: running flag, PC and the pending redirect.
    bit          m_run = 1'b0;
    logic [31:0] m_pc  = RV;
    bit          m_pv  = 1'b0;
    logic [31:0] m_pt  = 32'h0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic bit target_bad(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return (t % INC) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs and predict the outputs seen after the next rising edge.
    task automatic drive(input bit rst, input bit st, input bit e, input bit j,
                         input logic [31:0] jt, input bit b, input logic [31:0] bt);
        exp_t        x;
        logic [31:0] dest;
        @(negedge clock);
        reset = rst; stall = st; exc = e; jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt;
        x.redir = 1'b0;
        x.mis   = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_pc = RV; m_pv = 1'b0; x.valid = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1; m_pc = RV; m_pv = 1'b0; x.valid = 1'b1;
        end else begin
            x.valid = 1'b1;
            if (e) begin
                m_pc = EV; m_pv = 1'b0; x.redir = 1'b1;
            end else if (st) begin
                if (j || b) begin
                    m_pt = j ? jt : bt;
                    m_pv = 1'b1;
                end
            end else if (j || b || m_pv) begin
                dest = j ? jt : (b ? bt : m_pt);
                m_pv = 1'b0;
                x.redir = 1'b1;
                if (target_bad(dest)) begin
                    m_pc = EV; x.mis = 1'b1;
                end else begin
                    m_pc = dest;
                end
            end else begin
                m_pc = m_pc + INC;
            end
        end
        x.pc   = m_pc;
        x.plus = m_pc + INC;
        sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Monitor: compare whatever the DUT presents after each edge against the oldest prediction.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("PC_out", PC_out, e.pc);
            check("PC_plus", PC_plus, e.plus);
            check("pc_valid", {31'h0, pc_valid}, {31'h0, e.valid});
            check("redirected", {31'h0, redirected}, {31'h0, e.redir});
            check("misalign", {31'h0, misalign}, {31'h0, e.mis});
        end
    end

    initial begin
        logic [31:0] t1;
        logic [31:0] t2;
        int          budget;
        reset = 1'b1; stall = 1'b0; exc = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 32'h0; branch_target = 32'h0;

        // Reset, boot and sequential fetch: 0, 0, 4, 8, C.
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        idle(4);
        // Wrap from FFFF_FFFC to 0.
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        idle(2);
        // Jump beats branch.
        drive(0, 0, 0, 1, 32'h0000_0100, 1, 32'h0000_0200);
        idle(1);
        // Stalled branches: newest pending target wins, then sequential from it.
        drive(0, 1, 0, 0, 32'h0, 1, 32'h0000_0040);
        drive(0, 1, 0, 0, 32'h0, 1, 32'h0000_0060);
        drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
        idle(2);
        // Exception under stall clears a pending redirect.
        drive(0, 1, 0, 0, 32'h0, 1, 32'h0000_0300);
        drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
        idle(1);
        // Exception beats jump.
        drive(0, 0, 1, 1, 32'h0000_0500, 0, 32'h0);
        idle(1);
        // Misaligned jump (trapped only with alignment checking) and misaligned pending target.
        drive(0, 0, 0, 1, 32'h0000_0102, 0, 32'h0);
        idle(1);
        drive(0, 1, 0, 0, 32'h0, 1, 32'h0000_0203);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        idle(1);
        // Mid-operation reset with a pending redirect.
        drive(0, 1, 0, 1, 32'h0000_0700, 0, 32'h0);
        drive(1, 0, 0, 1, 32'h0000_0900, 0, 32'h0);
        idle(3);

        // Randomized traffic with occasional resets; targets mostly aligned.
        for (int i = 0; i < 400; i++) begin
            t1 = $urandom();
            t2 = $urandom();
            if ($urandom_range(0, 7) != 0) t1 = t1 & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) != 0) t2 = t2 & 32'hFFFF_FFFC;
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 4) == 0), t1,
                  ($urandom_range(0, 3) == 0), t2);
        end
        idle(2);

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
